// File: rtl/block_stream_gen_pkg.sv
// ============================================================================
// Module      : block_stream_gen_pkg
// Description : Shared constants and types for the begin/end keyword stream
//               (op codes, delimiter character, case delta, token lengths).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package block_stream_gen_pkg;

  // Command op codes
  localparam logic [1:0] OP_BEGIN = 2'd0;
  localparam logic [1:0] OP_END   = 2'd1;
  localparam logic [1:0] OP_CHAR  = 2'd2;
  localparam logic [1:0] OP_SPACE = 2'd3;

  // Character constants
  localparam logic [7:0] CHR_SPACE  = 8'h20;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  // Token lengths including the trailing delimiter
  localparam logic [2:0] LEN_BEGIN = 3'd6;
  localparam logic [2:0] LEN_END   = 3'd4;
  localparam logic [2:0] LEN_TOKEN = 3'd1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Number of characters a command expands to
  function automatic logic [2:0] op_len(input logic [1:0] op);
    logic [2:0] len;
    case (op)
      OP_BEGIN: len = LEN_BEGIN;
      OP_END:   len = LEN_END;
      default:  len = LEN_TOKEN;
    endcase
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/block_kw_rom.sv
// ============================================================================
// Module      : block_kw_rom
// Description : Combinational keyword ROM. Maps (is_end, idx) to the
//               lowercase character of "begin " or "end ".
// Ports       : is_end_i  in  1  select "end " (1) or "begin " (0)
//               idx_i     in  3  character index within the keyword
//               char_o    out 8  lowercase ASCII character
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_kw_rom
  import block_stream_gen_pkg::*;
(
  input  logic       is_end_i,
  input  logic [2:0] idx_i,
  output logic [7:0] char_o
);

  // Any index past the letters yields the delimiter.
  always_comb begin
    char_o = CHR_SPACE;
    case ({is_end_i, idx_i})
      4'b0_000: char_o = 8'h62; // b
      4'b0_001: char_o = 8'h65; // e
      4'b0_010: char_o = 8'h67; // g
      4'b0_011: char_o = 8'h69; // i
      4'b0_100: char_o = 8'h6E; // n
      4'b1_000: char_o = 8'h65; // e
      4'b1_001: char_o = 8'h6E; // n
      4'b1_010: char_o = 8'h64; // d
      default:  char_o = CHR_SPACE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/block_stream_gen.sv
// ============================================================================
// Module      : block_stream_gen
// Description : Transmit side of the begin/end keyword stream. Expands token
//               commands into an ASCII character stream on a valid/ready
//               interface and tracks nesting depth and balance.
// Config      : MIXED_CASE_EN - per-letter case select from cmd_case[4:0];
//               when undefined cmd_case[0] selects case for the whole word.
// Ports       : clk        in   1        clock, rising edge
//               reset      in   1        async active-low reset
//               cmd_valid  in   1        command present
//               cmd_ready  out  1        command can be accepted
//               cmd_op     in   2        0=BEGIN 1=END 2=CHAR 3=SPACE
//               cmd_char   in   8        raw byte for CHAR
//               cmd_case   in   5        keyword case select
//               out_valid  out  1        out_char valid
//               out_ready  in   1        sink accepts out_char
//               out_char   out  8        ASCII character
//               depth      out  DEPTH_W  current nesting depth
//               err        out  1        sticky underflow/overflow flag
//               balanced   out  1        (depth==0) && !err
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_stream_gen
  import block_stream_gen_pkg::*;
#(
  parameter int DEPTH_W   = 9,
  parameter int MAX_DEPTH = 511
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [7:0]         cmd_char,
  input  logic [4:0]         cmd_case,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_char,
  output logic [DEPTH_W-1:0] depth,
  output logic               err,
  output logic               balanced
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = MAX_DEPTH[DEPTH_W-1:0];
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};

`ifdef MIXED_CASE_EN
  localparam int CASE_W = 5;
`else
  localparam int CASE_W = 1;
  // Upper case bits have no function in this build.
  logic unused_case_bits;
  assign unused_case_bits = ^cmd_case[4:1];
`endif

  state_e              state_q, state_d;
  logic [2:0]          idx_q;
  logic [2:0]          len_q;
  logic [1:0]          op_q;
  logic [7:0]          raw_q;
  logic [CASE_W-1:0]   case_q;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                err_q, err_d;
  logic                balanced_q;

  logic                accept;
  logic                beat;
  logic                last_beat;
  logic                kw_up;
  logic [7:0]          rom_char;
  logic [7:0]          emit_char;

  assign accept    = cmd_valid && cmd_ready;
  assign beat      = out_valid && out_ready;
  assign last_beat = beat && (idx_q == (len_q - 3'd1));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EMIT;
      ST_EMIT: if (last_beat) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready = 1'b1;
      ST_EMIT: out_valid = 1'b1;
      default: cmd_ready = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequence latch and character index
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= 3'd0;
      len_q  <= LEN_TOKEN;
      op_q   <= OP_SPACE;
      raw_q  <= CHR_SPACE;
      case_q <= '0;
    end else if (accept) begin
      idx_q  <= 3'd0;
      len_q  <= op_len(cmd_op);
      op_q   <= cmd_op;
      raw_q  <= cmd_char;
      case_q <= cmd_case[CASE_W-1:0];
    end else if (beat) begin
      idx_q  <= idx_q + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Depth tracking; updated in the acceptance cycle
  // --------------------------------------------------------------------------
  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    if (accept) begin
      if (cmd_op == OP_BEGIN) begin
        if (depth_q < DEPTH_MAX) depth_d = depth_q + DEPTH_ONE;
        else                     err_d   = 1'b1;
      end else if (cmd_op == OP_END) begin
        if (depth_q > DEPTH_ZERO) depth_d = depth_q - DEPTH_ONE;
        else                      err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q    <= DEPTH_ZERO;
      err_q      <= 1'b0;
      balanced_q <= 1'b1;
    end else begin
      depth_q    <= depth_d;
      err_q      <= err_d;
      balanced_q <= (depth_d == DEPTH_ZERO) && !err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Character generation
  // --------------------------------------------------------------------------
  block_kw_rom u_kw_rom (
    .is_end_i (op_q == OP_END),
    .idx_i    (idx_q),
    .char_o   (rom_char)
  );

  always_comb begin
    kw_up = 1'b0;
`ifdef MIXED_CASE_EN
    case (idx_q)
      3'd0:    kw_up = case_q[0];
      3'd1:    kw_up = case_q[1];
      3'd2:    kw_up = case_q[2];
      3'd3:    kw_up = case_q[3];
      3'd4:    kw_up = case_q[4];
      default: kw_up = 1'b0;
    endcase
`else
    kw_up = case_q[0];
`endif
  end

  always_comb begin
    emit_char = CHR_SPACE;
    if (state_q == ST_EMIT) begin
      case (op_q)
        OP_CHAR:  emit_char = raw_q;
        OP_SPACE: emit_char = CHR_SPACE;
        // The delimiter is never case-shifted.
        default:  emit_char = (kw_up && (rom_char != CHR_SPACE)) ?
                              (rom_char - CASE_DELTA) : rom_char;
      endcase
    end
  end

  assign out_char = emit_char;
  assign depth    = depth_q;
  assign err      = err_q;
  assign balanced = balanced_q;

endmodule

`default_nettype wire

// File: tb/tb_block_stream_gen.sv
// ============================================================================
// Module      : tb_block_stream_gen
// Description : Self-checking bench for block_stream_gen. Expected characters
//               are queued when a command is sent and compared as beats occur.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_stream_gen;

  localparam logic [1:0] T_BEGIN = 2'd0;
  localparam logic [1:0] T_END   = 2'd1;
  localparam logic [1:0] T_CHAR  = 2'd2;
  localparam logic [1:0] T_SPACE = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_char = 8'h00;
  logic [4:0] cmd_case = 5'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_char;
  logic [8:0] depth;
  logic       err;
  logic       balanced;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  block_stream_gen #(.DEPTH_W(9), .MAX_DEPTH(511)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_char  (cmd_char),
    .cmd_case  (cmd_case),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .depth     (depth),
    .err       (err),
    .balanced  (balanced)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted beat pops one expected character.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_beat observed=%0h expected=none", out_char);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        assert (out_char === e) else begin
          fails++;
          $error("FAIL stream_char observed=%0h expected=%0h", out_char, e);
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] op, input logic [7:0] ch, input logic [4:0] cs);
    string kw;
    logic [7:0] c;
    logic up;
    if (op == T_CHAR) begin
      exp_q.push_back(ch);
    end else if (op == T_SPACE) begin
      exp_q.push_back(8'h20);
    end else begin
      kw = (op == T_BEGIN) ? "begin" : "end";
      for (int i = 0; i < kw.len(); i++) begin
        c = kw[i];
`ifdef MIXED_CASE_EN
        up = cs[i];
`else
        up = cs[0];
`endif
        if (up) c = c - 8'h20;
        exp_q.push_back(c);
      end
      exp_q.push_back(8'h20);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after acceptance, #1 past the edge.
  task automatic send(input logic [1:0] op, input logic [7:0] ch, input logic [4:0] cs);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      tests++;
      fails++;
      $error("FAIL send_timeout observed=busy expected=ready");
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_char  = ch;
    cmd_case  = cs;
    push_exp(op, ch, cs);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && cmd_ready) && n < 50) begin
      step();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    exp_q.delete();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // 1: reset state
    do_reset();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 8'h20);
    chk("rst_depth", depth, 0);
    chk("rst_err", err, 0);
    chk("rst_balanced", balanced, 1);

    // 2: BEGIN lowercase, six consecutive beats starting after acceptance
    send(T_BEGIN, 8'h00, 5'b00000);
    chk("t2_depth", depth, 1);
    chk("t2_balanced", balanced, 0);
    chk("t2_first_char", out_char, 8'h62);
    for (int i = 0; i < 6; i++) begin
      chk("t2_valid_run", out_valid, 1);
      step();
    end
    chk("t2_done", out_valid, 0);
    chk("t2_bubble_ready", cmd_ready, 1);
    wait_idle("t2_drain");

    // 3: END uppercase
    send(T_END, 8'h00, 5'b00001);
    chk("t3_depth", depth, 0);
    chk("t3_balanced", balanced, 1);
    wait_idle("t3_drain");

    // CHAR and SPACE, including a literal space byte
    send(T_CHAR, 8'h78, 5'b11111);
    chk("char_depth", depth, 0);
    wait_idle("char_drain");
    send(T_CHAR, 8'h20, 5'b00000);
    wait_idle("char_space_drain");
    send(T_SPACE, 8'h41, 5'b11111);
    wait_idle("space_drain");
    chk("char_balanced", balanced, 1);

    // 5: BEGIN with a 3-cycle stall at idx 2
    send(T_BEGIN, 8'h00, 5'b00000);
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_stall_char", out_char, 8'h67);
      chk("t5_stall_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    wait_idle("t5_drain");
    send(T_END, 8'h00, 5'b00000);
    wait_idle("t5_end_drain");
    chk("t5_balanced", balanced, 1);

    // 4: END underflow from reset, err sticky
    do_reset();
    send(T_END, 8'h00, 5'b00000);
    chk("t4_err", err, 1);
    chk("t4_depth", depth, 0);
    chk("t4_balanced", balanced, 0);
    wait_idle("t4_drain");
    send(T_BEGIN, 8'h00, 5'b00000);
    chk("t4_begin_depth", depth, 1);
    chk("t4_begin_err", err, 1);
    wait_idle("t4_begin_drain");
    send(T_END, 8'h00, 5'b00000);
    chk("t4_end_depth", depth, 0);
    chk("t4_end_err", err, 1);
    chk("t4_end_balanced", balanced, 0);
    wait_idle("t4_end_drain");

    // Overflow at MAX_DEPTH
    do_reset();
    for (int i = 0; i < 511; i++) begin
      send(T_BEGIN, 8'h00, 5'b00000);
      wait_idle("ovf_fill_drain");
    end
    chk("ovf_full_depth", depth, 511);
    chk("ovf_full_err", err, 0);
    send(T_BEGIN, 8'h00, 5'b00001);
    chk("ovf_depth_hold", depth, 511);
    chk("ovf_err", err, 1);
    chk("ovf_balanced", balanced, 0);
    wait_idle("ovf_drain");

    // 6: asynchronous reset mid-emission
    do_reset();
    send(T_BEGIN, 8'h00, 5'b00000);
    step();
    step();
    chk("t6_third_char", out_char, 8'h67);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    exp_q.delete();
    step();
    reset = 1'b1;
    #1;
    chk("t6_ready", cmd_ready, 1);
    chk("t6_depth", depth, 0);
    step();
    chk("t6_idle_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
